bsg_cam_1r1w_write_manager: RTL and testbench

Write-side controller for bsg_cam_1r1w_sync_unmanaged. It accepts insert, invalidate-way and flush requests over a valid/ready handshake and chooses the target way. Empty ways are used first, then a round-robin victim. It drives the CAM's one-hot w_v_i / w_set_not_clear_i / w_tag_i / w_data_i and consumes the CAM's w_empty_o. The lookup side of the CAM is untouched.

---
 rtl/bsg_cam_1r1w_write_manager_pkg.sv | 16 +
 rtl/bsg_cam_1r1w_write_manager_victim_rr.sv | 26 ++
 rtl/bsg_cam_1r1w_write_manager.sv | 142 ++++++++++++++
 tb/tb_bsg_cam_1r1w_write_manager.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cam_1r1w_write_manager_pkg.sv
// Shared types for the CAM write manager: request opcodes and controller states.
package bsg_cam_write_manager_pkg;

    typedef enum logic [1:0] {
        e_cam_insert    = 2'd0,
        e_cam_inval_way = 2'd1,
        e_cam_flush     = 2'd2,
        e_cam_nop       = 2'd3
    } bsg_cam_op_e;

    typedef enum logic {
        e_idle  = 1'b0,
        e_flush = 1'b1
    } bsg_cam_wm_state_e;

endpackage

// File: rtl/bsg_cam_1r1w_write_manager_victim_rr.sv
// Round-robin victim pointer: advances on victim inserts, returns to way 0 on clear.
module bsg_cam_victim_rr
    import bsg_cam_write_manager_pkg::*;
#(
    parameter int els_p = 4,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance_i,
    input  logic                 clear_i,
    output logic [lg_els_lp-1:0] idx_o
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_o <= '0;
        end else if (clear_i) begin
            idx_o <= '0;
        end else if (advance_i) begin
            // Explicit wrap so non-power-of-two way counts stay in range
            idx_o <= (idx_o == lg_els_lp'(els_p - 1)) ? '0 : idx_o + lg_els_lp'(1);
        end
    end

endmodule

// File: rtl/bsg_cam_1r1w_write_manager.sv
// Write-side controller for bsg_cam_1r1w_sync_unmanaged: picks a way for inserts
// (empty ways first, round-robin victim otherwise), and sequences invalidates/flushes.
module bsg_cam_1r1w_write_manager
    import bsg_cam_write_manager_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int tag_width_p  = 8,
    parameter int data_width_p = 16,
    localparam int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [1:0]              op_i,
    input  logic [tag_width_p-1:0]  tag_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic [lg_els_lp-1:0]    way_i,
    input  logic [els_p-1:0]        w_empty_i,
    output logic [els_p-1:0]        w_v_o,
    output logic                    w_set_not_clear_o,
    output logic [tag_width_p-1:0]  w_tag_o,
    output logic [data_width_p-1:0] w_data_o,
    output logic [lg_els_lp-1:0]    way_o,
    output logic                    evict_o
);

    function automatic logic [els_p-1:0] way_one_hot(input logic [lg_els_lp-1:0] idx);
        logic [els_p-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    bsg_cam_wm_state_e    state_r;
    bsg_cam_op_e          op;
    logic [lg_els_lp-1:0] flush_cnt_r;
    logic [els_p-1:0]     pending_r;
    logic [els_p-1:0]     avail;
    logic                 avail_any;
    logic [lg_els_lp-1:0] avail_idx;
    logic [lg_els_lp-1:0] rr_idx;
    logic [lg_els_lp-1:0] ins_idx;
    logic                 accept;
    logic                 flush_last;
    logic                 inval_in_range;
    logic                 rr_advance;
    logic                 rr_clear;

    assign op      = bsg_cam_op_e'(op_i);
    assign ready_o = reset & (state_r == e_idle);
    assign accept  = v_i & ready_o;

    // w_empty_i still shows last cycle's target as empty, so mask it out
    assign avail = w_empty_i & ~pending_r;

    always_comb begin
        avail_any = 1'b0;
        avail_idx = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (avail[i]) begin
                avail_any = 1'b1;
                avail_idx = lg_els_lp'(i);
            end
        end
    end

    assign ins_idx        = avail_any ? avail_idx : rr_idx;
    assign inval_in_range = (int'(way_i) < els_p);
    assign flush_last     = (state_r == e_flush) && (flush_cnt_r == lg_els_lp'(els_p - 1));
    assign rr_advance     = accept && (op == e_cam_insert) && !avail_any;
    assign rr_clear       = flush_last;

    bsg_cam_victim_rr #(
        .els_p(els_p)
    ) u_victim_rr (
        .clk      (clk),
        .reset    (reset),
        .advance_i(rr_advance),
        .clear_i  (rr_clear),
        .idx_o    (rr_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r           <= e_idle;
            flush_cnt_r       <= '0;
            pending_r         <= '0;
            w_v_o             <= '0;
            w_set_not_clear_o <= 1'b0;
            w_tag_o           <= '0;
            w_data_o          <= '0;
            way_o             <= '0;
            evict_o           <= 1'b0;
        end else begin
            w_v_o     <= '0;
            evict_o   <= 1'b0;
            pending_r <= '0;
            case (state_r)
                e_idle: begin
                    if (accept) begin
                        case (op)
                            e_cam_insert: begin
                                w_v_o             <= way_one_hot(ins_idx);
                                pending_r         <= way_one_hot(ins_idx);
                                w_set_not_clear_o <= 1'b1;
                                w_tag_o           <= tag_i;
                                w_data_o          <= data_i;
                                way_o             <= ins_idx;
                                evict_o           <= !avail_any && !w_empty_i[rr_idx];
                            end
                            e_cam_inval_way: begin
                                if (inval_in_range) begin
                                    w_v_o             <= way_one_hot(way_i);
                                    pending_r         <= way_one_hot(way_i);
                                    w_set_not_clear_o <= 1'b0;
                                    way_o             <= way_i;
                                end
                            end
                            e_cam_flush: begin
                                state_r     <= e_flush;
                                flush_cnt_r <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                e_flush: begin
                    w_v_o             <= way_one_hot(flush_cnt_r);
                    w_set_not_clear_o <= 1'b0;
                    way_o             <= flush_cnt_r;
                    flush_cnt_r       <= flush_cnt_r + lg_els_lp'(1);
                    if (flush_last) begin
                        state_r <= e_idle;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_cam_1r1w_write_manager.sv
// Self-checking bench for bsg_cam_1r1w_write_manager with an attached CAM empty-vector model.
module tb_bsg_cam_1r1w_write_manager;

    localparam int ELS = 4;
    localparam int TW  = 8;
    localparam int DW  = 16;
    localparam int LG  = 2;

    logic          clk;
    logic          reset;
    logic          v_i;
    logic          ready_o;
    logic [1:0]    op_i;
    logic [TW-1:0] tag_i;
    logic [DW-1:0] data_i;
    logic [LG-1:0] way_i;
    logic [ELS-1:0] w_empty_i;
    logic [ELS-1:0] w_v_o;
    logic          w_set_not_clear_o;
    logic [TW-1:0] w_tag_o;
    logic [DW-1:0] w_data_o;
    logic [LG-1:0] way_o;
    logic          evict_o;

    int checks;
    int failures;

    // Reference model state
    int            m_rr;
    int            m_last;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;

    // CAM model: writes land on the edge after w_v_o is presented
    logic [ELS-1:0] cam_empty;
    assign w_empty_i = cam_empty;

    always @(posedge clk) begin
        for (int i = 0; i < ELS; i++) begin
            if (w_v_o[i]) cam_empty[i] <= !w_set_not_clear_o;
        end
    end

    bsg_cam_1r1w_write_manager #(
        .els_p(ELS), .tag_width_p(TW), .data_width_p(DW)
    ) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
        .tag_i(tag_i), .data_i(data_i), .way_i(way_i), .w_empty_i(w_empty_i),
        .w_v_o(w_v_o), .w_set_not_clear_o(w_set_not_clear_o), .w_tag_o(w_tag_o),
        .w_data_o(w_data_o), .way_o(way_o), .evict_o(evict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_insert(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        int exp_way;
        logic exp_ev;
        logic [ELS-1:0] exp_v;
        @(negedge clk);
        v_i = 1'b1; op_i = 2'd0; tag_i = tag; data_i = data;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ins_ready got=%b want=1", ready_o);
        end
        exp_way = -1;
        exp_ev  = 1'b0;
        for (int i = 0; i < ELS; i++) begin
            if (exp_way < 0 && cam_empty[i] && i != m_last) exp_way = i;
        end
        if (exp_way < 0) begin
            exp_way = m_rr;
            exp_ev  = !cam_empty[m_rr];
            m_rr    = (m_rr + 1) % ELS;
        end
        exp_v = '0;
        exp_v[exp_way] = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        checks++;
        if ({w_v_o, w_set_not_clear_o, w_tag_o, w_data_o, way_o, evict_o} !==
            {exp_v, 1'b1, tag, data, LG'(exp_way), exp_ev}) begin
            failures++;
            $display("FAIL insert got v=%b set=%b tag=%h data=%h way=%0d ev=%b want v=%b set=1 tag=%h data=%h way=%0d ev=%b",
                     w_v_o, w_set_not_clear_o, w_tag_o, w_data_o, way_o, evict_o,
                     exp_v, tag, data, exp_way, exp_ev);
        end
        m_last = exp_way;
        m_tag  = tag;
        m_data = data;
    endtask

    task automatic do_inval(input int way);
        logic [ELS-1:0] exp_v;
        @(negedge clk);
        v_i = 1'b1; op_i = 2'd1; way_i = LG'(way);
        exp_v = '0;
        exp_v[way] = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        checks++;
        if ({w_v_o, w_set_not_clear_o, w_tag_o, w_data_o, way_o, evict_o} !==
            {exp_v, 1'b0, m_tag, m_data, LG'(way), 1'b0}) begin
            failures++;
            $display("FAIL inval got v=%b set=%b tag=%h data=%h way=%0d ev=%b want v=%b set=0 tag=%h data=%h way=%0d ev=0",
                     w_v_o, w_set_not_clear_o, w_tag_o, w_data_o, way_o, evict_o,
                     exp_v, m_tag, m_data, way);
        end
        m_last = way;
    endtask

    task automatic do_idle(input int n, input bit as_nop);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            v_i  = as_nop;
            op_i = 2'd3;
            @(posedge clk); #1;
            v_i = 1'b0;
            checks++;
            if (w_v_o !== '0 || ready_o !== 1'b1) begin
                failures++;
                $display("FAIL idle got v=%b ready=%b want v=0000 ready=1", w_v_o, ready_o);
            end
            m_last = -1;
        end
    endtask

    task automatic do_flush(input bit abort);
        logic [ELS-1:0] exp_v;
        @(negedge clk);
        v_i = 1'b1; op_i = 2'd2;
        @(posedge clk); #1;
        v_i = 1'b0;
        checks++;
        if (w_v_o !== '0 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_accept got v=%b ready=%b want v=0000 ready=0", w_v_o, ready_o);
        end
        for (int k = 0; k < ELS; k++) begin
            @(posedge clk); #1;
            exp_v = '0;
            exp_v[k] = 1'b1;
            checks++;
            if (w_v_o !== exp_v || w_set_not_clear_o !== 1'b0 || way_o !== LG'(k) ||
                ready_o !== (k == ELS - 1)) begin
                failures++;
                $display("FAIL flush_step%0d got v=%b set=%b way=%0d ready=%b want v=%b set=0 way=%0d ready=%b",
                         k, w_v_o, w_set_not_clear_o, way_o, ready_o, exp_v, k, (k == ELS - 1));
            end
            if (abort) begin
                @(negedge clk);
                reset = 1'b0;
                #1;
                checks++;
                if (w_v_o !== '0 || ready_o !== 1'b0 || w_tag_o !== '0 || w_data_o !== '0) begin
                    failures++;
                    $display("FAIL flush_abort got v=%b ready=%b tag=%h data=%h want all zero",
                             w_v_o, ready_o, w_tag_o, w_data_o);
                end
                m_rr = 0; m_last = -1; m_tag = '0; m_data = '0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        m_rr   = 0;
        m_last = -1;
    endtask

    task automatic check_cam(input string name, input logic [ELS-1:0] want);
        checks++;
        if (cam_empty !== want) begin
            failures++;
            $display("FAIL %s cam_empty got=%b want=%b", name, cam_empty, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; v_i = 1'b0; op_i = 2'd0; tag_i = '0; data_i = '0; way_i = '0;
        cam_empty = '1;
        m_rr = 0; m_last = -1; m_tag = '0; m_data = '0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({w_v_o, w_set_not_clear_o, w_tag_o, w_data_o, way_o, evict_o, ready_o} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b set=%b tag=%h data=%h way=%0d ev=%b ready=%b want all zero",
                     w_v_o, w_set_not_clear_o, w_tag_o, w_data_o, way_o, evict_o, ready_o);
        end
        @(negedge clk);
        reset = 1'b1;
        do_idle(1, 1'b0);
    endtask

    task automatic test_first_inserts();
        do_insert(8'h00, 16'hdead);
        do_insert(8'h11, 16'hbeef);
        do_idle(1, 1'b0);
        check_cam("after_two_inserts", 4'b1100);
    endtask

    task automatic test_fill_and_evict();
        do_insert(8'h22, 16'h2222);
        do_insert(8'h33, 16'h3333);
        do_idle(1, 1'b0);
        check_cam("full", 4'b0000);
        do_insert(8'h44, 16'h4444);
        for (int i = 0; i < 4; i++) do_insert(8'h50 + 8'(i), 16'h5000 + 16'(i));
    endtask

    task automatic test_invalidate();
        do_inval(2);
        do_idle(1, 1'b0);
        check_cam("after_inval", 4'b0100);
        do_insert(8'h66, 16'h6666);
        do_insert(8'h77, 16'h7777);
        do_idle(1, 1'b1);
    endtask

    task automatic test_flush();
        do_flush(1'b0);
        do_idle(1, 1'b0);
        check_cam("after_flush", 4'b1111);
    endtask

    task automatic test_reset_mid_flush();
        for (int i = 0; i < 4; i++) do_insert(8'h80 + 8'(i), 16'h8000 + 16'(i));
        do_idle(1, 1'b0);
        do_flush(1'b1);
        do_idle(3, 1'b0);
        check_cam("after_abort", 4'b0000);
        do_insert(8'h99, 16'h9999);
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      do_insert(TW'($urandom), DW'($urandom));
            else if (r < 75) do_inval($urandom_range(0, ELS - 1));
            else if (r < 85) do_idle(1, 1'b0);
            else if (r < 93) do_idle(1, 1'b1);
            else             do_flush(1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_inserts();
        test_fill_and_evict();
        test_invalidate();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
